// File: rtl/int_reg_file_sb.sv
// Integer register file with per-register pending-write scoreboard.
// Decode gets two bypassed read ports and a RAW/WAW hazard stall; writeback retires pending writes.
module int_reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              dec_valid_i,
    input  logic [ADDR_W-1:0] dec_read_addr_a_i,
    input  logic [ADDR_W-1:0] dec_read_addr_b_i,
    input  logic [ADDR_W-1:0] dec_write_addr_i,
    input  logic              dec_int_write_enable_i,
    output logic [DATA_W-1:0] dec_read_data_a_o,
    output logic [DATA_W-1:0] dec_read_data_b_o,
    output logic              dec_stall_o,
    input  logic              wb_int_write_enable_i,
    input  logic [ADDR_W-1:0] wb_write_addr_i,
    input  logic [DATA_W-1:0] wb_write_data_i,
    output logic [NREG-1:0]   pending_o
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_next;
    logic [NREG-1:0]   wb_clr;
    logic              wb_hit;
    logic              src_hz_a;
    logic              src_hz_b;
    logic              dst_hz;
    logic              stall;
    logic              issue;

    // Gating with rsn_i keeps bypass and writes off while reset is held.
    assign wb_hit = rsn_i && wb_int_write_enable_i && (wb_write_addr_i != '0);

    always_comb begin
        wb_clr = '0;
        for (int r = 1; r < NREG; r++) begin
            wb_clr[r] = wb_hit && (wb_write_addr_i == ADDR_W'(r));
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_hit) begin
            regs[wb_write_addr_i] <= wb_write_data_i;
        end
    end

    always_comb begin
        dec_read_data_a_o = '0;
        if (dec_read_addr_a_i != '0) begin
            if (wb_hit && (wb_write_addr_i == dec_read_addr_a_i)) begin
                dec_read_data_a_o = wb_write_data_i;
            end else begin
                dec_read_data_a_o = regs[dec_read_addr_a_i];
            end
        end
    end

    always_comb begin
        dec_read_data_b_o = '0;
        if (dec_read_addr_b_i != '0) begin
            if (wb_hit && (wb_write_addr_i == dec_read_addr_b_i)) begin
                dec_read_data_b_o = wb_write_data_i;
            end else begin
                dec_read_data_b_o = regs[dec_read_addr_b_i];
            end
        end
    end

    // A retiring writeback in the same cycle resolves the hazard, since its data is bypassed.
    assign src_hz_a = pending[dec_read_addr_a_i] && !wb_clr[dec_read_addr_a_i];
    assign src_hz_b = pending[dec_read_addr_b_i] && !wb_clr[dec_read_addr_b_i];
    assign dst_hz   = dec_int_write_enable_i && pending[dec_write_addr_i]
                      && !wb_clr[dec_write_addr_i];

    assign stall = rsn_i && dec_valid_i && (src_hz_a || src_hz_b || dst_hz);
    assign issue = rsn_i && dec_valid_i && dec_int_write_enable_i && !stall
                   && (dec_write_addr_i != '0);

    assign dec_stall_o = stall;

    // A new issue supersedes a producer retiring on the same cycle, so set wins over clear.
    always_comb begin
        pending_next = pending;
        for (int r = 1; r < NREG; r++) begin
            if (issue && (dec_write_addr_i == ADDR_W'(r))) begin
                pending_next[r] = 1'b1;
            end else if (wb_clr[r]) begin
                pending_next[r] = 1'b0;
            end
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign pending_o = pending;

endmodule

// File: tb/tb_int_reg_file_sb.sv
// Directed bench for int_reg_file_sb: a vector table walked cycle by cycle plus a mid-run reset sequence.
module tb_int_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;

    logic              clk_i = 1'b0;
    logic              rsn_i;
    logic              dec_valid_i;
    logic [ADDR_W-1:0] dec_read_addr_a_i;
    logic [ADDR_W-1:0] dec_read_addr_b_i;
    logic [ADDR_W-1:0] dec_write_addr_i;
    logic              dec_int_write_enable_i;
    logic [DATA_W-1:0] dec_read_data_a_o;
    logic [DATA_W-1:0] dec_read_data_b_o;
    logic              dec_stall_o;
    logic              wb_int_write_enable_i;
    logic [ADDR_W-1:0] wb_write_addr_i;
    logic [DATA_W-1:0] wb_write_data_i;
    logic [NREG-1:0]   pending_o;

    int errors = 0;
    int checks = 0;

    int_reg_file_sb #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk_i                  (clk_i),
        .rsn_i                  (rsn_i),
        .dec_valid_i            (dec_valid_i),
        .dec_read_addr_a_i      (dec_read_addr_a_i),
        .dec_read_addr_b_i      (dec_read_addr_b_i),
        .dec_write_addr_i       (dec_write_addr_i),
        .dec_int_write_enable_i (dec_int_write_enable_i),
        .dec_read_data_a_o      (dec_read_data_a_o),
        .dec_read_data_b_o      (dec_read_data_b_o),
        .dec_stall_o            (dec_stall_o),
        .wb_int_write_enable_i  (wb_int_write_enable_i),
        .wb_write_addr_i        (wb_write_addr_i),
        .wb_write_data_i        (wb_write_data_i),
        .pending_o              (pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  wa;
        logic        dwe;
        logic        wbwe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [31:0] e_rda;
        logic [31:0] e_rdb;
        logic        e_stall;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        dec_valid_i            = v.valid;
        dec_read_addr_a_i      = v.ra;
        dec_read_addr_b_i      = v.rb;
        dec_write_addr_i       = v.wa;
        dec_int_write_enable_i = v.dwe;
        wb_int_write_enable_i  = v.wbwe;
        wb_write_addr_i        = v.wba;
        wb_write_data_i        = v.wbd;
    endtask

    initial begin
        //                vld ra  rb  wa  dwe wbwe wba wbd           rda           rdb           stl pend
        vecs.push_back('{0, 0,  0,  0,  0,  0,  0,  32'h0,        32'h0,        32'h0,        0, 32'h0});     // 0 reset state
        vecs.push_back('{0, 5,  0,  0,  0,  1,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 32'h0});     // 1 write x5, bypass
        vecs.push_back('{0, 5,  5,  0,  0,  0,  0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0});     // 2 readback both ports
        vecs.push_back('{0, 0,  0,  0,  0,  1,  0,  32'h1234,     32'h0,        32'h0,        0, 32'h0});     // 3 write x0
        vecs.push_back('{0, 0,  5,  0,  0,  0,  0,  32'h0,        32'h0,        32'hDEADBEEF, 0, 32'h0});     // 4 x0 still zero
        vecs.push_back('{1, 1,  2,  3,  1,  0,  0,  32'h0,        32'h0,        32'h0,        0, 32'h0});     // 5 issue dest x3
        vecs.push_back('{1, 0,  3,  0,  0,  0,  0,  32'h0,        32'h0,        32'h0,        1, 32'h8});     // 6 RAW stall
        vecs.push_back('{1, 0,  3,  0,  0,  0,  0,  32'h0,        32'h0,        32'h0,        1, 32'h8});     // 7 stall holds
        vecs.push_back('{1, 0,  3,  0,  0,  1,  3,  32'h42,       32'h0,        32'h42,       0, 32'h8});     // 8 wb x3 resolves
        vecs.push_back('{0, 0,  3,  0,  0,  0,  0,  32'h0,        32'h0,        32'h42,       0, 32'h0});     // 9 x3 cleared
        vecs.push_back('{1, 0,  0,  7,  1,  0,  0,  32'h0,        32'h0,        32'h0,        0, 32'h0});     // 10 issue dest x7
        vecs.push_back('{1, 7,  0,  0,  0,  1,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        0, 32'h80});    // 11 bypass pending x7
        vecs.push_back('{0, 7,  0,  0,  0,  0,  0,  32'h0,        32'hA5A5A5A5, 32'h0,        0, 32'h0});     // 12 x7 retired
        vecs.push_back('{1, 0,  0,  9,  1,  0,  0,  32'h0,        32'h0,        32'h0,        0, 32'h0});     // 13 issue dest x9
        vecs.push_back('{1, 0,  0,  9,  1,  0,  0,  32'h0,        32'h0,        32'h0,        1, 32'h200});   // 14 WAW stall
        vecs.push_back('{1, 0,  0,  9,  1,  1,  9,  32'h99,       32'h0,        32'h0,        0, 32'h200});   // 15 set+clear same cycle
        vecs.push_back('{0, 9,  0,  0,  0,  0,  0,  32'h0,        32'h99,       32'h0,        0, 32'h200});   // 16 set won
        vecs.push_back('{0, 9,  0,  0,  0,  1,  9,  32'h100,      32'h100,      32'h0,        0, 32'h200});   // 17 second writer retires
        vecs.push_back('{0, 9,  0,  0,  0,  0,  0,  32'h0,        32'h100,      32'h0,        0, 32'h0});     // 18 x9 clear
        vecs.push_back('{1, 0,  0,  0,  1,  0,  0,  32'h0,        32'h0,        32'h0,        0, 32'h0});     // 19 issue dest x0
        vecs.push_back('{1, 0,  0,  0,  1,  0,  0,  32'h0,        32'h0,        32'h0,        0, 32'h0});     // 20 no stall on x0
        vecs.push_back('{0, 0,  0,  0,  0,  1,  12, 32'hCAFE,     32'h0,        32'h0,        0, 32'h0});     // 21 wb non-pending x12
        vecs.push_back('{0, 12, 0,  0,  0,  0,  0,  32'h0,        32'hCAFE,     32'h0,        0, 32'h0});     // 22 x12 written
        vecs.push_back('{1, 0,  0,  4,  1,  0,  0,  32'h0,        32'h0,        32'h0,        0, 32'h0});     // 23 issue dest x4
        vecs.push_back('{0, 4,  0,  0,  0,  0,  0,  32'h0,        32'h0,        32'h0,        0, 32'h10});    // 24 no stall w/o valid
        vecs.push_back('{1, 4,  0,  0,  0,  0,  0,  32'h0,        32'h0,        32'h0,        1, 32'h10});    // 25 stall on A
        vecs.push_back('{1, 0,  4,  0,  0,  0,  0,  32'h0,        32'h0,        32'h0,        1, 32'h10});    // 26 stall on B

        rsn_i = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset pending", pending_o, 32'h0);
        rsn_i = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d rda", i), dec_read_data_a_o, vecs[i].e_rda);
            chk($sformatf("v%0d rdb", i), dec_read_data_b_o, vecs[i].e_rdb);
            chk($sformatf("v%0d stall", i), {31'h0, dec_stall_o}, {31'h0, vecs[i].e_stall});
            chk($sformatf("v%0d pending", i), pending_o, vecs[i].e_pend);
            @(posedge clk_i);
            #1;
        end

        // Mid-run reset with x4 pending and a writeback to x6 in flight.
        dec_valid_i            = 1'b1;
        dec_read_addr_a_i      = 5'd6;
        dec_read_addr_b_i      = 5'd4;
        dec_write_addr_i       = 5'd0;
        dec_int_write_enable_i = 1'b0;
        wb_int_write_enable_i  = 1'b1;
        wb_write_addr_i        = 5'd6;
        wb_write_data_i        = 32'h66;
        #2;
        chk("pre-rst bypass", dec_read_data_a_o, 32'h66);
        chk("pre-rst stall", {31'h0, dec_stall_o}, 32'h1);
        #1 rsn_i = 1'b0;
        #1;
        chk("rst pending", pending_o, 32'h0);
        chk("rst rda", dec_read_data_a_o, 32'h0);
        chk("rst stall", {31'h0, dec_stall_o}, 32'h0);
        dec_read_addr_b_i = 5'd5;
        #1;
        chk("rst rdb x5", dec_read_data_b_o, 32'h0);
        @(posedge clk_i);
        #1;
        wb_int_write_enable_i = 1'b0;
        #1 rsn_i = 1'b1;
        #1;
        chk("post-rst x6", dec_read_data_a_o, 32'h0);
        chk("post-rst x5", dec_read_data_b_o, 32'h0);
        dec_read_addr_b_i = 5'd4;
        #1;
        chk("post-rst x4 stall", {31'h0, dec_stall_o}, 32'h0);
        dec_read_addr_b_i = 5'd9;
        wb_int_write_enable_i = 1'b1;
        wb_write_data_i       = 32'h6161;
        @(posedge clk_i);
        #1;
        wb_int_write_enable_i = 1'b0;
        #1;
        chk("post-rst wb x6", dec_read_data_a_o, 32'h6161);
        chk("post-rst x9", dec_read_data_b_o, 32'h0);
        chk("post-rst pending", pending_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
